// File: rtl/alu_harvard.sv
// ============================================================================
// Module   : alu_harvard
// Brief    : Two-stage 32-bit ALU; operand/select register then result register.
//            Optional registered zero flag enabled by macro ALU_HARVARD_ZERO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_harvard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_sel,
`ifdef ALU_HARVARD_ZERO_EN
  output logic        zero,
`endif
  output logic [31:0] r
);

  localparam logic [2:0] c_OP_AND  = 3'b000;
  localparam logic [2:0] c_OP_OR   = 3'b001;
  localparam logic [2:0] c_OP_ADD  = 3'b010;
  localparam logic [2:0] c_OP_XOR  = 3'b011;
  localparam logic [2:0] c_OP_NOR  = 3'b100;
  localparam logic [2:0] c_OP_SLTU = 3'b101;
  localparam logic [2:0] c_OP_SUB  = 3'b110;
  localparam logic [2:0] c_OP_SLT  = 3'b111;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_sel;
  logic [31:0] r_result;
  logic [31:0] w_result;

  // Stage 1: capture operands and select together so a later select change
  // cannot alter an operation already in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= 32'h0;
      r_b   <= 32'h0;
      r_sel <= 3'b000;
    end else begin
      r_a   <= a;
      r_b   <= b;
      r_sel <= alu_sel;
    end
  end

  always_comb begin
    w_result = 32'h0;
    case (r_sel)
      c_OP_AND:  w_result = r_a & r_b;
      c_OP_OR:   w_result = r_a | r_b;
      c_OP_ADD:  w_result = r_a + r_b;
      c_OP_XOR:  w_result = r_a ^ r_b;
      c_OP_NOR:  w_result = ~(r_a | r_b);
      c_OP_SLTU: w_result = {31'h0, (r_a < r_b)};
      c_OP_SUB:  w_result = r_a - r_b;
      c_OP_SLT:  w_result = {31'h0, ($signed(r_a) < $signed(r_b))};
      default:   w_result = 32'h0;
    endcase
  end

  // Stage 2: result register drives r directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= 32'h0;
    end else begin
      r_result <= w_result;
    end
  end

  assign r = r_result;

`ifdef ALU_HARVARD_ZERO_EN
  logic r_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zero <= 1'b1;
    end else begin
      r_zero <= (w_result == 32'h0);
    end
  end

  assign zero = r_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_harvard.sv
// ============================================================================
// Module   : tb_alu_harvard
// Brief    : Scoreboard bench for alu_harvard (define ALU_HARVARD_ZERO_EN to
//            also check the zero flag).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_harvard;

  localparam logic [2:0] c_AND  = 3'b000;
  localparam logic [2:0] c_OR   = 3'b001;
  localparam logic [2:0] c_ADD  = 3'b010;
  localparam logic [2:0] c_XOR  = 3'b011;
  localparam logic [2:0] c_NOR  = 3'b100;
  localparam logic [2:0] c_SLTU = 3'b101;
  localparam logic [2:0] c_SUB  = 3'b110;
  localparam logic [2:0] c_SLT  = 3'b111;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alu_sel;
  logic [31:0] r;
`ifdef ALU_HARVARD_ZERO_EN
  logic        zero;
`endif

  int          n_tests;
  int          n_fail;
  logic [31:0] sb[$];
  logic [31:0] exp_r;

  alu_harvard dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .alu_sel (alu_sel),
`ifdef ALU_HARVARD_ZERO_EN
    .zero    (zero),
`endif
    .r       (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present inputs mid-cycle, then return 1 time unit after the capturing edge.
  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [2:0] s);
    @(negedge clk);
    a       = x;
    b       = y;
    alu_sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive($urandom, $urandom, 3'(i + 2));
      n_tests++;
      if (r !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: r=%h expected %h", i, r, 32'h0);
      end
`ifdef ALU_HARVARD_ZERO_EN
      n_tests++;
      if (zero !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_zero[%0d]: zero=%b expected 1", i, zero);
      end
`endif
    end
    rst_n = 1'b1;
    drive(32'h0, 32'h0, c_AND);
    sb.delete();
  endtask

  task automatic test_directed();
    logic [31:0] ta[14];
    logic [31:0] tb_[14];
    logic [2:0]  ts[14];
    logic [31:0] te[14];
    ta = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
           32'h1, 32'h80000000, 32'h80000000, 32'h7, 32'h7};
    tb_ = '{32'h1, 32'h0000FFFF, 32'h7, 32'h1, 32'h1,
            32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
            32'hFFFFFFFF, 32'h1, 32'h1, 32'h7, 32'h7};
    ts = '{c_ADD, c_ADD, c_SUB, c_SLT, c_SLTU,
           c_AND, c_OR, c_XOR, c_NOR,
           c_SLT, c_SLT, c_SLTU, c_SLT, c_SUB};
    te = '{32'h0, 32'h0001FFFE, 32'hFFFFFFFE, 32'h1, 32'h0,
           32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F,
           32'h0, 32'h1, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i <= 14; i++) begin
      if (i < 14) drive(ta[i], tb_[i], ts[i]);
      else        drive(32'h0, 32'h0, c_AND);
      if (sb.size() != 0) begin
        exp_r = sb.pop_front();
        n_tests++;
        if (r !== exp_r) begin
          n_fail++;
          $display("FAIL directed[%0d]: r=%h expected %h", i - 1, r, exp_r);
        end
`ifdef ALU_HARVARD_ZERO_EN
        n_tests++;
        if (zero !== (exp_r == 32'h0)) begin
          n_fail++;
          $display("FAIL directed_zero[%0d]: zero=%b expected %b", i - 1, zero, exp_r == 32'h0);
        end
`endif
      end
      if (i < 14) sb.push_back(te[i]);
    end
  endtask

  task automatic test_add_stream();
    logic [31:0] xa;
    logic [31:0] xb;
    xa = 32'h23456789;
    xb = 32'h34567891;
    for (int i = 0; i <= 10000; i++) begin
      if (i < 10000) drive(xa, xb, c_ADD);
      else           drive(32'h0, 32'h0, c_AND);
      if (sb.size() != 0) begin
        exp_r = sb.pop_front();
        n_tests++;
        if (r !== exp_r) begin
          n_fail++;
          $display("FAIL add_stream[%0d]: r=%h expected %h", i - 1, r, exp_r);
        end
      end
      if (i == 0) sb.push_back(32'h579BE01A);
      else if (i < 10000) sb.push_back(xa + xb);
      xa = xa + 32'h23456789;
      xb = xb + 32'h34567891;
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      drive(32'(2 * i + 1), 32'(2 * i + 2), c_ADD);
      if (sb.size() != 0) begin
        exp_r = sb.pop_front();
        n_tests++;
        if (r !== exp_r) begin
          n_fail++;
          $display("FAIL midrst_pre[%0d]: r=%h expected %h", i, r, exp_r);
        end
      end
      sb.push_back(32'(4 * i + 3));
    end
    rst_n = 1'b0;
    drive(32'h7, 32'h8, c_ADD);
    sb.delete();
    n_tests++;
    if (r !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_at: r=%h expected %h", r, 32'h0);
    end
    rst_n = 1'b1;
    drive(32'h9, 32'hA, c_ADD);
    n_tests++;
    if (r !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_flush: r=%h expected %h", r, 32'h0);
    end
    sb.push_back(32'h13);
    drive(32'h0, 32'h0, c_AND);
    exp_r = sb.pop_front();
    n_tests++;
    if (r !== exp_r) begin
      n_fail++;
      $display("FAIL midrst_first: r=%h expected %h", r, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h00001000, 32'h00000234, c_ADD);
    sb.push_back(32'h00001234);
    drive(32'h00001000, 32'h00000234, c_SUB);
    exp_r = sb.pop_front();
    n_tests++;
    if (r !== exp_r) begin
      n_fail++;
      $display("FAIL b2b_sum: r=%h expected %h", r, exp_r);
    end
    sb.push_back(32'h00000DCC);
    drive(32'h0, 32'h0, c_AND);
    exp_r = sb.pop_front();
    n_tests++;
    if (r !== exp_r) begin
      n_fail++;
      $display("FAIL b2b_diff: r=%h expected %h", r, exp_r);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    a       = 32'h0;
    b       = 32'h0;
    alu_sel = 3'b000;
    test_reset();
    test_directed();
    test_add_stream();
    test_reset_midstream();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
